// File: rtl/uart_rx_fifo_if.sv
// CPU-side bundle for the UART receiver: serial line in, FIFO head/status and
// pop/clear strobes. The peripheral uses the slave view, the CPU decoder the master view.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          uart_rx;
  logic          rd_en;
  logic          err_clr;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;

  modport master (
    output uart_rx, rd_en, err_clr,
    input  rx_data, rx_empty, rx_count, frame_err, overrun
  );

  modport slave (
    input  uart_rx, rd_en, err_clr,
    output rx_data, rx_empty, rx_count, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver, 16x oversampled, feeding a show-ahead byte FIFO with
// sticky frame-error and overrun flags for the CPU MMIO read path.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int OVS_RAW = CLK_FREQ / (BAUD * 16);
  localparam int OVS_DIV = (OVS_RAW < 1) ? 1 : OVS_RAW;
  localparam int DIV_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             div_restart;
  state_e           state_q, state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, frame_set;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, pop, push_ok, overrun_set;
  logic             frame_err_q, overrun_q;

  assign rx_s = sync_q[1];
  assign tick = (div_q == DIV_W'(OVS_DIV - 1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_set   = 1'b0;
    div_restart = 1'b0;
    unique case (state_q)
      IDLE: if (!rx_s) begin
        state_d     = START;
        tick_cnt_d  = 4'd0;
        div_restart = 1'b1;
      end
      START: if (tick) begin
        if (tick_cnt_q == 4'd7) begin
          tick_cnt_d = 4'd0;
          bit_d      = 3'd0;
          state_d    = rx_s ? IDLE : DATA;
        end else tick_cnt_d = tick_cnt_q + 4'd1;
      end
      DATA: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          push      = rx_s;
          frame_set = !rx_s;
          state_d   = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (div_restart || tick) div_d = '0;
    else                     div_d = div_q + DIV_W'(1);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      div_q      <= '0;
      state_q    <= IDLE;
      tick_cnt_q <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      sync_q     <= {sync_q[0], bus.uart_rx};
      div_q      <= div_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign pop         = bus.rd_en && !empty;
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  // NOTE: the storage array has no reset; empty gating on rx_data keeps its
  // power-up contents invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_q + CW'(push_ok) - CW'(pop);
      // A new event in the same cycle as err_clr keeps the flag set.
      frame_err_q <= frame_set   | (frame_err_q & ~bus.err_clr);
      overrun_q   <= overrun_set | (overrun_q   & ~bus.err_clr);
    end
  end

  assign bus.rx_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.rx_empty  = empty;
  assign bus.rx_count  = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo: drives 8N1 frames at 160 clk/bit
// and compares the outputs against a queue-based model of the receiver.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = 160;
  // Start edge driven at a falling edge: 2 sync flops + 1 cycle into START,
  // then 8 + 16*9 ticks of 10 clocks to the stop-bit sample edge.
  localparam int STOP_EDGE = 3 + 10 * (8 + 16 * 9);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int           total = 0;
  int           bad   = 0;
  byte unsigned exp_q[$];
  bit           exp_fe = 1'b0;
  bit           exp_ov = 1'b0;
  byte unsigned fill_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_empty"}, bus.rx_empty,  exp_q.size() == 0);
    check({tag, "_count"}, bus.rx_count,  exp_q.size());
    check({tag, "_ferr"},  bus.frame_err, exp_fe);
    check({tag, "_ovr"},   bus.overrun,   exp_ov);
    if (exp_q.size() > 0) check({tag, "_data"}, bus.rx_data, exp_q[0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  bus.rx_data,   8'h00);
    check({tag, "_empty"}, bus.rx_empty,  1'b1);
    check({tag, "_count"}, bus.rx_count,  0);
    check({tag, "_ferr"},  bus.frame_err, 1'b0);
    check({tag, "_ovr"},   bus.overrun,   1'b0);
  endtask

  // Line bits, LSB first; starts and ends on a falling clock edge.
  task automatic drive_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.uart_rx = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic model_good_byte(input byte unsigned b);
    if (exp_q.size() == DEPTH) exp_ov = 1'b1;
    else                       exp_q.push_back(b);
  endtask

  task automatic send_byte(input byte unsigned b);
    drive_bits({1'b1, b, 1'b0}, 10);
    bus.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    model_good_byte(b);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() > 0) check(tag, bus.rx_data, exp_q.pop_front());
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    bus.uart_rx = 1'b1;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5: still empty after the data bits, visible once the stop bit is sampled.
    drive_bits({1'b1, 8'hA5, 1'b0}, 9);
    check("a5_pre_stop_empty", bus.rx_empty, 1'b1);
    bus.uart_rx = 1'b1;
    repeat (BIT_CLKS + 4) @(negedge clk);
    model_good_byte(8'hA5);
    check_state("a5");
    pop_check("a5_pop");
    check_state("a5_after_pop");

    // Pop on empty FIFO is ignored.
    pop_check("empty_pop");
    check_state("empty_pop");

    // Short low glitch is rejected.
    bus.uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check_state("glitch");

    // 0x3C with stop bit held low (break), then a clean 0x11.
    drive_bits({1'b0, 8'h3C, 1'b0}, 9);
    bus.uart_rx = 1'b0;
    repeat (300) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    exp_fe = 1'b1;
    check_state("break");
    send_byte(8'h11);
    check_state("after_break");
    pop_check("byte11_pop");
    pulse_err_clr();
    check_state("ferr_clr");

    // Overrun: 17 bytes with no reads.
    for (int i = 0; i <= 16; i++) send_byte(byte'(i));
    check_state("overrun");
    for (int i = 0; i < 16; i++) pop_check("ovr_pop");
    check_state("ovr_drained");
    pulse_err_clr();
    check_state("ovr_clr");

    // Fill with random bytes, then pop exactly in the stop-sample cycle of 0x77.
    for (int i = 0; i < DEPTH; i++) begin
      fill_b = byte'($urandom_range(255));
      send_byte(fill_b);
    end
    check_state("full");
    fork
      begin
        drive_bits({1'b1, 8'h77, 1'b0}, 10);
        bus.uart_rx = 1'b1;
      end
      begin
        repeat (STOP_EDGE - 1) @(negedge clk);
        check("head_at_pop", bus.rx_data, exp_q[0]);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    repeat (4) @(negedge clk);
    check_state("full_push_pop");
    for (int i = 0; i < DEPTH; i++) pop_check("full_pop");
    check_state("full_drained");

    // Reset in the middle of 0xFF with a byte already queued.
    send_byte(8'h42);
    check_state("pre_reset");
    drive_bits({1'b1, 8'hFF, 1'b0}, 4);
    reset = 1'b0;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("mid_rst");
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_state("post_rst");
    send_byte(8'h5A);
    check_state("after_rst_5a");
    pop_check("5a_pop");
    check_state("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
